// File: rtl/ift_sram_arb_pkg.sv
// Shared types and address-decode helpers for the taint-tracking SRAM bank arbiter.
package ift_sram_arb_pkg;

    localparam int unsigned IdxWidth = 8;

    typedef struct packed {
        logic                valid;
        logic [IdxWidth-1:0] idx;
        logic                taint;
    } rsp_entry_t;

    function automatic logic [31:0] word_of(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input int unsigned off_bits);
        logic [31:0] off;
        off = addr - base;
        return off >> off_bits;
    endfunction

    function automatic logic [31:0] bank_of(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input int unsigned off_bits,
                                            input int unsigned sel_bits);
        return word_of(addr, base, off_bits) & ((32'd1 << sel_bits) - 32'd1);
    endfunction

    function automatic logic [31:0] bank_addr_of(input logic [31:0] addr,
                                                 input logic [31:0] base,
                                                 input int unsigned off_bits,
                                                 input int unsigned sel_bits,
                                                 input int unsigned addr_bits);
        return (word_of(addr, base, off_bits) >> sel_bits) & ((32'd1 << addr_bits) - 32'd1);
    endfunction

    // Address bits that can influence bank selection through the base subtraction.
    function automatic logic [31:0] cone_mask(input int unsigned off_bits);
        return ~((32'd1 << off_bits) - 32'd1);
    endfunction

endpackage

// File: rtl/ift_sram_bank_arbiter_rr.sv
// Cyclic round-robin pick: first eligible requester at or after the pointer, with grant taint.
module ift_rr_arbiter #(
    parameter int unsigned NumReq = 2,
    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic [NumReq-1:0] eligible,
    input  logic              eligible_t,
    input  logic [IdxW-1:0]   ptr,
    input  logic              ptr_t,
    output logic [NumReq-1:0] gnt,
    output logic [IdxW-1:0]   idx,
    output logic              any,
    output logic [NumReq-1:0] gnt_t
);

    int unsigned cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand = (32'(ptr) + i) % NumReq;
            if (!any && eligible[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IdxW'(cand);
            end
        end
    end

    // Every grant bit depends on the tainted selection, so all are tainted together.
    assign gnt_t = {NumReq{eligible_t | ptr_t}};

endmodule

// File: rtl/ift_sram_bank_arbiter.sv
// Round-robin arbiter in front of one interleaved SRAM bank, with CellIFT-style taint shadows.
module ift_sram_bank_arbiter
    import ift_sram_arb_pkg::*;
#(
    parameter int unsigned NumMasters = 2,
    parameter int unsigned NumBanks   = 8,
    parameter int unsigned BankId     = 0,
    parameter int unsigned NumWords   = 1024,
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned ByteWidth  = 8,
    parameter int unsigned Latency    = 1,
    parameter logic [31:0] AddrOffset = 32'h1C000000,
    parameter int unsigned NumTaints  = 1,
    localparam int unsigned BankAddrWidth = $clog2(NumWords),
    localparam int unsigned WidthBytes    = (DataWidth + ByteWidth - 1) / ByteWidth,
    localparam int unsigned WordOffBits   = $clog2(WidthBytes),
    localparam int unsigned BankSelBits   = $clog2(NumBanks)
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic [NumMasters-1:0]                         req_i,
    input  logic [NumMasters-1:0]                         we_i,
    input  logic [NumMasters-1:0][31:0]                   addr_i,
    input  logic [NumMasters-1:0][DataWidth-1:0]          wdata_i,
    input  logic [NumMasters-1:0][WidthBytes-1:0]         be_i,
    output logic [NumMasters-1:0]                         gnt_o,
    output logic [NumMasters-1:0]                         rvalid_o,
    output logic [NumMasters-1:0][DataWidth-1:0]          rdata_o,
    output logic                                          sram_req_o,
    output logic                                          sram_we_o,
    output logic [BankAddrWidth-1:0]                      sram_addr_o,
    output logic [DataWidth-1:0]                          sram_wdata_o,
    output logic [WidthBytes-1:0]                         sram_be_o,
    input  logic [DataWidth-1:0]                          sram_rdata_i,
    input  logic [NumTaints-1:0]                          clk_i_t0,
    input  logic [NumTaints-1:0]                          rst_ni_t0,
    input  logic [NumTaints-1:0][NumMasters-1:0]          req_i_t0,
    input  logic [NumTaints-1:0][NumMasters-1:0]          we_i_t0,
    input  logic [NumTaints-1:0][NumMasters-1:0][31:0]    addr_i_t0,
    input  logic [NumTaints-1:0][NumMasters-1:0][DataWidth-1:0]  wdata_i_t0,
    input  logic [NumTaints-1:0][NumMasters-1:0][WidthBytes-1:0] be_i_t0,
    output logic [NumTaints-1:0][NumMasters-1:0]          gnt_o_t0,
    output logic [NumTaints-1:0][NumMasters-1:0]          rvalid_o_t0,
    output logic [NumTaints-1:0][NumMasters-1:0][DataWidth-1:0]  rdata_o_t0,
    output logic [NumTaints-1:0]                          sram_req_o_t0,
    output logic [NumTaints-1:0]                          sram_we_o_t0,
    output logic [NumTaints-1:0][BankAddrWidth-1:0]       sram_addr_o_t0,
    output logic [NumTaints-1:0][DataWidth-1:0]           sram_wdata_o_t0,
    output logic [NumTaints-1:0][WidthBytes-1:0]          sram_be_o_t0,
    input  logic [NumTaints-1:0][DataWidth-1:0]           sram_rdata_i_t0
);

    localparam int unsigned IdxW = (NumMasters > 1) ? $clog2(NumMasters) : 1;

    logic [NumMasters-1:0] eligible;
    logic                  sel_t;
    logic                  sel_taint;
    logic [DataWidth-1:0]  wdata_any_t;
    logic [NumMasters-1:0] gnt;
    logic [NumMasters-1:0] gnt_t;
    logic [IdxW-1:0]       win_idx;
    logic                  win_any;
    logic [IdxW-1:0]       rr_q;
    logic [IdxW-1:0]       rr_next;
    logic                  rr_tainted_q;
    rsp_entry_t            pipe_q [Latency];
    rsp_entry_t            head;
    rsp_entry_t            rsp;

    logic                     req_t;
    logic                     we_t;
    logic [BankAddrWidth-1:0] addr_t;
    logic [DataWidth-1:0]     wdata_t;
    logic [WidthBytes-1:0]    be_t;
    logic [NumMasters-1:0]    rvalid_t;
    logic [NumMasters-1:0][DataWidth-1:0] rdata_t;

    logic unused_taint;
    assign unused_taint = ^{clk_i_t0, rst_ni_t0};

    always_comb begin
        eligible    = '0;
        sel_t       = 1'b0;
        wdata_any_t = '0;
        for (int unsigned m = 0; m < NumMasters; m++) begin
            if (req_i[m] && bank_of(addr_i[m], AddrOffset, WordOffBits, BankSelBits) == 32'(BankId))
                eligible[m] = 1'b1;
            if (req_i_t0[0][m])
                sel_t = 1'b1;
            if (req_i[m] && |(addr_i_t0[0][m] & cone_mask(WordOffBits)))
                sel_t = 1'b1;
            if (req_i[m])
                wdata_any_t = wdata_any_t | wdata_i_t0[0][m];
        end
    end

    assign sel_taint = sel_t | rr_tainted_q;

    ift_rr_arbiter #(
        .NumReq(NumMasters)
    ) u_arb (
        .eligible   (eligible),
        .eligible_t (sel_t),
        .ptr        (rr_q),
        .ptr_t      (rr_tainted_q),
        .gnt        (gnt),
        .idx        (win_idx),
        .any        (win_any),
        .gnt_t      (gnt_t)
    );

    assign gnt_o    = gnt;
    assign gnt_o_t0 = {NumTaints{gnt_t}};

    always_comb begin
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_be_o    = '0;
        req_t        = 1'b0;
        we_t         = 1'b0;
        addr_t       = '0;
        wdata_t      = '0;
        be_t         = '0;
        if (win_any) begin
            sram_req_o   = 1'b1;
            sram_we_o    = we_i[win_idx];
            sram_addr_o  = BankAddrWidth'(bank_addr_of(addr_i[win_idx], AddrOffset, WordOffBits,
                                                       BankSelBits, BankAddrWidth));
            sram_wdata_o = wdata_i[win_idx];
            sram_be_o    = be_i[win_idx];
            req_t        = req_i_t0[0][win_idx];
            we_t         = we_i_t0[0][win_idx];
            addr_t       = addr_i_t0[0][win_idx][WordOffBits + BankSelBits +: BankAddrWidth];
            wdata_t      = wdata_i_t0[0][win_idx];
            be_t         = be_i_t0[0][win_idx];
        end
        // A tainted selection could have picked any requester, so widen to their union.
        if (sel_taint) begin
            req_t   = 1'b1;
            we_t    = 1'b1;
            addr_t  = '1;
            be_t    = '1;
            wdata_t = wdata_t | wdata_any_t;
        end
    end

    assign sram_req_o_t0   = {NumTaints{req_t}};
    assign sram_we_o_t0    = {NumTaints{we_t}};
    assign sram_addr_o_t0  = {NumTaints{addr_t}};
    assign sram_wdata_o_t0 = {NumTaints{wdata_t}};
    assign sram_be_o_t0    = {NumTaints{be_t}};

    assign rr_next = (32'(win_idx) == NumMasters - 1) ? '0 : win_idx + IdxW'(1);
    assign head    = '{valid: win_any, idx: IdxWidth'(win_idx), taint: sel_taint};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q         <= '0;
            rr_tainted_q <= 1'b0;
            for (int unsigned i = 0; i < Latency; i++)
                pipe_q[i] <= '0;
        end else begin
            if (win_any) begin
                rr_q <= rr_next;
                if (sel_t)
                    rr_tainted_q <= 1'b1;
            end
            pipe_q[0] <= head;
            for (int unsigned i = 1; i < Latency; i++)
                pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign rsp = pipe_q[Latency-1];

    always_comb begin
        rvalid_o = '0;
        rdata_o  = '0;
        rvalid_t = '0;
        rdata_t  = '0;
        for (int unsigned m = 0; m < NumMasters; m++) begin
            rvalid_o[m] = rsp.valid && (rsp.idx == IdxWidth'(m));
            rdata_o[m]  = sram_rdata_i;
            rvalid_t[m] = rsp.taint;
            rdata_t[m]  = sram_rdata_i_t0[0] | {DataWidth{rsp.taint}};
        end
    end

    assign rvalid_o_t0 = {NumTaints{rvalid_t}};
    assign rdata_o_t0  = {NumTaints{rdata_t}};

endmodule

// File: tb/tb_ift_sram_bank_arbiter.sv
// Directed bench: stimulus pushes expected responses, a negedge monitor pops and compares them.
module tb_ift_sram_bank_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]            req, we;
    logic [1:0][31:0]      addr, wdata;
    logic [1:0][3:0]       be;
    logic [0:0][1:0]       req_t, we_t;
    logic [0:0][1:0][31:0] addr_t, wdata_t;
    logic [0:0][1:0][3:0]  be_t;
    logic [0:0]            clk_t, rst_t;
    logic [0:0][31:0]      rdata_in_t;
    logic [31:0]           sram_rdata;

    logic [1:0]            gnt, rvalid;
    logic [1:0][31:0]      rdata;
    logic                  sram_req, sram_we;
    logic [9:0]            sram_addr;
    logic [31:0]           sram_wdata;
    logic [3:0]            sram_be;
    logic [0:0][1:0]       gnt_t, rvalid_t;
    logic [0:0][1:0][31:0] rdata_t;
    logic [0:0]            sram_req_t, sram_we_t;
    logic [0:0][9:0]       sram_addr_t;
    logic [0:0][31:0]      sram_wdata_t;
    logic [0:0][3:0]       sram_be_t;

    logic [1:0]            gnt2, rvalid2;
    logic [1:0][31:0]      rdata2;
    logic                  sram_req2, sram_we2;
    logic [9:0]            sram_addr2;
    logic [31:0]           sram_wdata2;
    logic [3:0]            sram_be2;
    logic [0:0][1:0]       gnt_t2, rvalid_t2;
    logic [0:0][1:0][31:0] rdata_t2;
    logic [0:0]            sram_req_t2, sram_we_t2;
    logic [0:0][9:0]       sram_addr_t2;
    logic [0:0][31:0]      sram_wdata_t2;
    logic [0:0][3:0]       sram_be_t2;

    assign clk_t      = '0;
    assign rst_t      = '0;
    assign rdata_in_t = '0;

    ift_sram_bank_arbiter #(.NumMasters(2), .NumBanks(8), .BankId(0), .Latency(1)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .be_i(be), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .sram_req_o(sram_req),
        .sram_we_o(sram_we), .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata),
        .sram_be_o(sram_be), .sram_rdata_i(sram_rdata), .clk_i_t0(clk_t), .rst_ni_t0(rst_t),
        .req_i_t0(req_t), .we_i_t0(we_t), .addr_i_t0(addr_t), .wdata_i_t0(wdata_t),
        .be_i_t0(be_t), .gnt_o_t0(gnt_t), .rvalid_o_t0(rvalid_t), .rdata_o_t0(rdata_t),
        .sram_req_o_t0(sram_req_t), .sram_we_o_t0(sram_we_t), .sram_addr_o_t0(sram_addr_t),
        .sram_wdata_o_t0(sram_wdata_t), .sram_be_o_t0(sram_be_t), .sram_rdata_i_t0(rdata_in_t)
    );

    ift_sram_bank_arbiter #(.NumMasters(2), .NumBanks(8), .BankId(0), .Latency(2)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .be_i(be), .gnt_o(gnt2), .rvalid_o(rvalid2), .rdata_o(rdata2), .sram_req_o(sram_req2),
        .sram_we_o(sram_we2), .sram_addr_o(sram_addr2), .sram_wdata_o(sram_wdata2),
        .sram_be_o(sram_be2), .sram_rdata_i(32'h0), .clk_i_t0(clk_t), .rst_ni_t0(rst_t),
        .req_i_t0(req_t), .we_i_t0(we_t), .addr_i_t0(addr_t), .wdata_i_t0(wdata_t),
        .be_i_t0(be_t), .gnt_o_t0(gnt_t2), .rvalid_o_t0(rvalid_t2), .rdata_o_t0(rdata_t2),
        .sram_req_o_t0(sram_req_t2), .sram_we_o_t0(sram_we_t2), .sram_addr_o_t0(sram_addr_t2),
        .sram_wdata_o_t0(sram_wdata_t2), .sram_be_o_t0(sram_be_t2), .sram_rdata_i_t0(rdata_in_t)
    );

    // Behavioural one-cycle bank behind the Latency=1 instance.
    logic [31:0] mem [1024];
    always @(posedge clk) begin
        if (sram_req) begin
            if (sram_we)
                mem[sram_addr] <= sram_wdata;
            sram_rdata <= mem[sram_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  rv;
        logic        chk;
        logic [31:0] data;
        int          at;
    } exp_t;

    exp_t q [$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] rv, input logic c, input logic [31:0] d);
        exp_t e;
        e.rv   = rv;
        e.chk  = c;
        e.data = d;
        e.at   = cyc + 1;
        q.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        req = '0; we = '0; addr = '0; wdata = '0; be = '0;
        req_t = '0; we_t = '0; addr_t = '0; wdata_t = '0; be_t = '0;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && rvalid != 2'b00) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL rsp_unexpected: got rvalid=%b at cycle %0d, required none", rvalid, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (rvalid !== e.rv || cyc != e.at ||
                    (e.chk && rdata[(e.rv == 2'b10) ? 1 : 0] !== e.data)) begin
                    n_bad++;
                    $display("FAIL rsp: got rvalid=%b cyc=%0d rdata=%h, required rvalid=%b cyc=%0d rdata=%h",
                             rvalid, cyc, rdata[(e.rv == 2'b10) ? 1 : 0], e.rv, e.at, e.data);
                end
            end
        end
    end

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("reset_outputs", 64'({gnt, rvalid, sram_req, sram_we, sram_addr, sram_be}), 64'h0);
        chk("reset_wdata", 64'(sram_wdata), 64'h0);
        chk("reset_taints", 64'({gnt_t, rvalid_t, sram_req_t, sram_we_t, sram_addr_t, sram_be_t,
                                 |rdata_t, |sram_wdata_t}), 64'h0);
        chk("reset_rr", 64'({u_dut.rr_q, u_dut.rr_tainted_q}), 64'h0);
        tick();

        // master0 writes word 1 of bank 0
        req = 2'b01; we = 2'b01; addr[0] = 32'h1C000020; wdata[0] = 32'hDEADBEEF; be[0] = 4'hF;
        #1;
        chk("wr_gnt", 64'(gnt), 64'h1);
        chk("wr_sram_addr", 64'(sram_addr), 64'h1);
        chk("wr_sram_ctl", 64'({sram_req, sram_we, sram_be}), 64'h3F);
        chk("wr_sram_wdata", 64'(sram_wdata), 64'hDEADBEEF);
        push(2'b01, 1'b0, 32'h0);
        tick(); idle();

        // master1 reads it back; pointer now favours master1
        req = 2'b10; addr[1] = 32'h1C000020;
        #1;
        chk("rd_gnt", 64'(gnt), 64'h2);
        push(2'b10, 1'b1, 32'hDEADBEEF);
        tick(); idle();

        // contention: both write every cycle, word 2 from master0, word 3 from master1
        for (int k = 0; k < 4; k++) begin
            req = 2'b11; we = 2'b11; be = {4'hF, 4'hF};
            addr[0] = 32'h1C000040; addr[1] = 32'h1C000060;
            wdata[0] = 32'h22220000 + 32'(k); wdata[1] = 32'h33330000 + 32'(k);
            #1;
            chk("rr_gnt", 64'(gnt), (k % 2 == 0) ? 64'h1 : 64'h2);
            chk("rr_sram_addr", 64'(sram_addr), (k % 2 == 0) ? 64'h2 : 64'h3);
            push((k % 2 == 0) ? 2'b01 : 2'b10, 1'b0, 32'h0);
            tick();
        end
        idle();

        // bank 1 address is never granted
        for (int k = 0; k < 3; k++) begin
            req = 2'b10; addr[1] = 32'h1C000004;
            #1;
            chk("other_bank", 64'({gnt, sram_req}), 64'h0);
            tick();
        end
        idle();

        // taint only below the word offset does not touch selection
        req = 2'b01; addr[0] = 32'h1C000040; addr_t[0][0] = 32'h3; wdata_t[0][0] = 32'hF0;
        #1;
        chk("low_taint_gnt_t", 64'(gnt_t), 64'h0);
        chk("low_taint_addr_t", 64'(sram_addr_t), 64'h0);
        chk("low_taint_wdata_t", 64'(sram_wdata_t), 64'hF0);
        push(2'b01, 1'b1, 32'h22220002);
        tick(); idle();

        // selection-cone taint on master0
        req = 2'b01; addr[0] = 32'h1C000040; addr_t[0][0] = 32'h100;
        wdata_t[0][0] = 32'h1; wdata_t[0][1] = 32'h0F00;
        #1;
        chk("sel_taint_gnt_t", 64'(gnt_t), 64'h3);
        chk("sel_taint_sram_t", 64'({sram_req_t, sram_we_t, sram_addr_t, sram_be_t}), 64'hFFFF);
        chk("sel_taint_wdata_t", 64'(sram_wdata_t), 64'h1);
        push(2'b01, 1'b1, 32'h22220002);
        tick(); idle();
        chk("rr_tainted_latch", 64'(u_dut.rr_tainted_q), 64'h1);
        chk("rsp_taint", 64'({rvalid_t, rdata_t[0][0]}), 64'h3FFFFFFFF);

        req = 2'b10; addr[1] = 32'h1C000060;
        #1;
        chk("sticky_gnt_t", 64'(gnt_t), 64'h3);
        push(2'b10, 1'b1, 32'h33330003);
        tick(); idle();
        tick();

        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        #1;
        chk("taint_cleared", 64'({u_dut.rr_tainted_q, gnt_t}), 64'h0);
        tick();

        // Latency=2 instance: response two cycles after grant
        req = 2'b01; addr[0] = 32'h1C000040;
        #1;
        chk("l2_gnt", 64'(gnt2), 64'h1);
        push(2'b01, 1'b1, 32'h22220002);
        tick(); idle();
        chk("l2_rvalid_c1", 64'(rvalid2), 64'h0);
        tick();
        chk("l2_rvalid_c2", 64'(rvalid2), 64'h1);
        tick();

        // grant, then reset on the following cycle: response must be dropped
        req = 2'b01; addr[0] = 32'h1C000040;
        #1;
        chk("l2_flight_gnt", 64'(gnt2), 64'h1);
        @(posedge clk);
        #1;
        idle();
        rst_n = 1'b0;
        #6 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("l2_reset_drop_c1", 64'({rvalid2, rvalid}), 64'h0);
        tick();
        chk("l2_reset_drop_c2", 64'({rvalid2, rvalid}), 64'h0);
        tick(); tick();

        chk("scoreboard_drained", 64'(q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ift_sram_bank_arbiter.md
# ift_sram_bank_arbiter

Taint-tracking round-robin arbiter that sits directly upstream of one interleaved `ift_sram` bank. It accepts TCDM-style req/gnt requests from `NumMasters` masters and keeps only those whose address decodes to this bank. It drives the bank's single SRAM port and routes the read data back, with `rvalid`, to the granted master after `Latency` cycles. Every control and data path carries a CellIFT-style `_t0` taint shadow, conservative wherever selection depends on tainted inputs.

## Interface
- `NumMasters`, 2: requesting masters, at least 2.
- `NumBanks`, 8: interleaved banks.
- `BankId`, 0: this bank's index.
- `NumWords`, 1024: words per bank.
- `DataWidth`, 32: data width.
- `ByteWidth`, 8: bits per byte enable.
- `Latency`, 1: SRAM read latency; must match the bank.
- `AddrOffset`, 32'h1C000000: base of the interleaved region.
- `NumTaints`, 1: must be 1.
- Derived, do not override: `BankAddrWidth`=$clog2(NumWords), `WidthBytes`=ceil(DataWidth/ByteWidth), `WordOffBits`=$clog2(WidthBytes), `BankSelBits`=$clog2(NumBanks).

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `req_i` in [NumMasters]: request.
- `we_i` in [NumMasters]: write enable.
- `addr_i` in [NumMasters][32]: byte address.
- `wdata_i` in [NumMasters][DataWidth]: write data.
- `be_i` in [NumMasters][WidthBytes]: byte enables.
- `gnt_o` out [NumMasters]: grant, combinational.
- `rvalid_o` out [NumMasters]: response valid.
- `rdata_o` out [NumMasters][DataWidth]: read data.
- `sram_req_o`, `sram_we_o` out 1 each: bank request and write enable.
- `sram_addr_o` out BankAddrWidth: bank word address.
- `sram_wdata_o` out DataWidth: bank write data.
- `sram_be_o` out WidthBytes: bank byte enables.
- `sram_rdata_i` in DataWidth: bank read data.
- Taint shadows: `clk_i_t0` and `rst_ni_t0` are inputs and are ignored. Every other port `x` has a `x_t0` of the same direction, prefixed by [NumTaints].

## Operation
- **Decode.**
  - `off = addr_i - AddrOffset`.
  - `word = off >> WordOffBits`.
  - `bank = word[BankSelBits-1:0]`.
  - `bank_addr = word[BankSelBits +: BankAddrWidth]`.
  - Master m is eligible when `req_i[m]` is set and `bank == BankId`.
  - Ineligible requests are never granted; an address outside the region wraps modulo 2^32 and is not flagged.
- **Arbitration.**
  - Pointer `rr_q`, width $clog2(NumMasters), resets to 0.
  - The winner is the first eligible master at or after `rr_q`, searching cyclically; at most one `gnt_o` bit is set.
  - On a grant, `rr_q` becomes winner+1, wrapping from NumMasters-1 to 0. Otherwise `rr_q` holds.
- **SRAM drive.**
  - `sram_req_o` is set when any master is granted; `we`/`addr`/`wdata`/`be` are the winner's fields.
  - With no grant, all outputs are 0.
- **Response pipeline.** A Latency-deep shift register carries valid and master index.
  - `rvalid_o[idx]` rises exactly `Latency` cycles after the grant, for both reads and writes.
  - `rdata_o[m] = sram_rdata_i` for every m; data is meaningful only with `rvalid_o[m]`.
- **Taint.**
  - `sel_t` is set when any `req_i_t0` is set, or any `addr_i_t0` bit of a requesting master falls in the bank-select or offset-subtraction cone. That cone is conservatively bits `[31:WordOffBits]`.
  - `gnt_o_t0[m] = sel_t | rr_tainted_q`.
  - `rr_tainted_q` is sticky: set by any grant while `sel_t`, cleared only by reset.
  - `sram_*_t0` equals the winner's `*_t0`. When `sel_t | rr_tainted_q`, these are ORed with all-ones on `req`, `we`, `addr` and `be`, and with the OR of all requesting masters' `wdata_i_t0` on `wdata`.
  - The response pipeline carries the grant taint: `rvalid_o_t0[m]` is the delayed taint.
  - `rdata_o_t0[m] = sram_rdata_i_t0 | {DataWidth{delayed taint}}`.

## Timing
- Reset values: `gnt_o`, `rvalid_o` and `sram_*` are 0 (combinational from the cleared state); `rr_q` is 0; pipeline valids are 0; `rr_tainted_q` is 0; all `_t0` outputs are 0.
- Grant is issued in the same cycle as the request. The response arrives exactly Latency cycles later, so throughput is one grant per cycle.
- Back-to-back grants to different masters produce back-to-back rvalids in grant order.
- Reset mid-flight drops pending responses: no `rvalid_o` is raised after reset deassertion for pre-reset grants.
- A request that is not granted must be held by the master; the arbiter keeps no request state.

## Structure
- Package `ift_sram_arb_pkg`:
  - the response-pipeline entry struct {valid, idx, taint};
  - address decode helper functions for bank and bank_addr.
- Sub-module `ift_rr_arbiter`: eligible vector plus pointer in, one-hot grant plus index out, with a taint output. It is natural to separate it and reuse it for other banks.

## Test plan
- Reset then idle: all outputs and `_t0` outputs are 0; `rr_q`=0.
- BankId=0, NumBanks=8, master0 write to 0x1C000020:
  - same cycle: `gnt_o`=01, `sram_addr_o`=1;
  - one cycle later: `rvalid_o`=01.
- Both masters request bank 0 continuously for four cycles: grants go 01,10,01,10 and rvalids follow each grant one cycle later.
- Master1 requests 0x1C000004 (bank 1): `gnt_o`=0 and `sram_req_o`=0 indefinitely.
- Master0 has `addr_i_t0`=0x100:
  - `gnt_o_t0` is set for both masters;
  - `rr_tainted_q` latches;
  - later clean requests still show `gnt_o_t0`=11 until reset.
- Latency=2, grant at cycle 5, reset asserted at cycle 6: no `rvalid_o` at cycle 7.
